// File: rtl/wbgpio_seq.sv
// Wishbone-programmable GPIO pin sequencer: plays a table of {gpio word, delay}
// steps onto the GPIO controller's wishbone port, one-shot or looping.
module wbgpio_seq #(
    parameter int unsigned LGSTEPS = 3,
    parameter int unsigned DW      = 24,
    parameter int unsigned TMO     = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [LGSTEPS+1:0]   i_wb_addr,
    input  logic [31:0]          i_wb_data,
    output logic                 o_wb_ack,
    output logic                 o_wb_stall,
    output logic [31:0]          o_wb_data,
    output logic                 o_gpio_cyc,
    output logic                 o_gpio_stb,
    output logic                 o_gpio_we,
    output logic [31:0]          o_gpio_data,
    input  logic                 i_gpio_ack,
    input  logic                 i_gpio_stall,
    output logic                 o_int
);
    localparam int unsigned AW     = LGSTEPS + 2;
    localparam int unsigned NSTEPS = 1 << LGSTEPS;
    localparam int unsigned TW     = $clog2(TMO + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAITACK, S_DELAY} state_t;

    state_t               state_q, state_d;
    logic [LGSTEPS-1:0]   step_q, step_d, last_q;
    logic                 loop_q, done_q, done_d, err_q, err_d, int_q, int_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [31:0]          gdata_q, gdata_d;
    logic                 cyc_q, stb_q, ack_q;
    logic [31:0]          rdata_q, rd_data;
    logic                 advance, acked;

    logic [31:0]          gpio_tab [NSTEPS];
    logic [DW-1:0]        dly_tab  [NSTEPS];

    logic                 bus_req, bus_wr, tab_sel, ctrl_sel, ctrl_wr, start_req, abort_req;
    logic [LGSTEPS-1:0]   tab_idx;

    assign bus_req   = i_wb_cyc && i_wb_stb;
    assign bus_wr    = bus_req && i_wb_we;
    assign tab_sel   = i_wb_addr[AW-1];
    assign ctrl_sel  = (i_wb_addr == '0);
    assign tab_idx   = i_wb_addr[LGSTEPS:1];
    assign ctrl_wr   = bus_wr && ctrl_sel;
    assign start_req = ctrl_wr && i_wb_data[0] && !i_wb_data[2];
    assign abort_req = ctrl_wr && i_wb_data[2];

    // Step table RAM, no reset
    always_ff @(posedge i_clk) begin
        if (bus_wr && tab_sel) begin
            if (i_wb_addr[0]) dly_tab[tab_idx] <= i_wb_data[DW-1:0];
            else              gpio_tab[tab_idx] <= i_wb_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (tab_sel) begin
            rd_data = i_wb_addr[0] ? 32'(dly_tab[tab_idx]) : gpio_tab[tab_idx];
        end else if (ctrl_sel) begin
            rd_data[0]              = (state_q != S_IDLE);
            rd_data[1]              = loop_q;
            rd_data[3]              = err_q;
            rd_data[4]              = done_q;
            rd_data[8 +: LGSTEPS]   = last_q;
            rd_data[16 +: LGSTEPS]  = step_q;
        end
    end

    // Slave side: single-cycle ack with registered read data
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            loop_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            ack_q <= bus_req;
            if (bus_req) rdata_q <= rd_data;
            if (ctrl_wr) begin
                loop_q <= i_wb_data[1];
                last_q <= i_wb_data[8 +: LGSTEPS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = done_q;
        err_d   = err_q;
        int_d   = 1'b0;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        gdata_d = gdata_q;
        advance = 1'b0;
        acked   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    step_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!i_gpio_stall) begin
                    tmo_d = '0;
                    if (i_gpio_ack) acked = 1'b1;
                    else            state_d = S_WAITACK;
                end
            end
            S_WAITACK: begin
                if (i_gpio_ack) begin
                    acked = 1'b1;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    int_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q - DW'(1);
                if (cnt_q == DW'(1)) advance = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A zero delay skips the DELAY state so the next strobe follows the ack directly
        if (acked) begin
            if (dly_tab[step_q] == '0) begin
                advance = 1'b1;
            end else begin
                cnt_d   = dly_tab[step_q];
                state_d = S_DELAY;
            end
        end
        if (advance) begin
            if (step_q == last_q) begin
                step_d = '0;
                if (loop_q) begin
                    state_d = S_WRITE;
                end else begin
                    done_d  = 1'b1;
                    int_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end else begin
                step_d  = step_q + LGSTEPS'(1);
                state_d = S_WRITE;
            end
        end
        if (abort_req) state_d = S_IDLE;
        // Latch the step word on entry to WRITE; hold it while the port stalls
        if (state_d == S_WRITE && !(state_q == S_WRITE && i_gpio_stall)) gdata_d = gpio_tab[step_d];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            int_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            gdata_q <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            gdata_q <= gdata_d;
            cyc_q   <= (state_d == S_WRITE) || (state_d == S_WAITACK);
            stb_q   <= (state_d == S_WRITE);
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = rdata_q;
    assign o_gpio_cyc  = cyc_q;
    assign o_gpio_stb  = stb_q;
    assign o_gpio_we   = stb_q;
    assign o_gpio_data = gdata_q;
    assign o_int       = int_q;
endmodule

// File: tb/tb_wbgpio_seq.sv
// Bench for wbgpio_seq: GPIO slave responder plus a cycle-level sequence model.
module tb_wbgpio_seq;
    localparam int LG  = 3;
    localparam int TMO = 15;

    logic        clk, rst;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack, o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_gpio_cyc, o_gpio_stb, o_gpio_we;
    logic [31:0] o_gpio_data;
    logic        i_gpio_ack, i_gpio_stall;
    logic        o_int;

    wbgpio_seq #(.LGSTEPS(LG), .DW(24), .TMO(TMO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
        .o_gpio_cyc(o_gpio_cyc), .o_gpio_stb(o_gpio_stb), .o_gpio_we(o_gpio_we),
        .o_gpio_data(o_gpio_data), .i_gpio_ack(i_gpio_ack), .i_gpio_stall(i_gpio_stall),
        .o_int(o_int)
    );

    int n_cmp = 0, n_fail = 0;
    int cyc_n = 0, cyc_hi = 0, viol = 0, wr_edge = 0;
    logic wr_ack;
    int rs_stall = 0, rs_lat = 1;
    bit rs_noack = 0;
    logic [31:0] rs_cap;
    int acc_edge[$], int_edge[$], exp_edge[$];
    logic [31:0] acc_data[$], exp_data[$];
    int exp_done;
    logic [31:0] tab_w [8];
    int tab_d [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (o_int === 1'b1) int_edge.push_back(cyc_n);
        if (o_gpio_cyc === 1'b1) cyc_hi++;
        if (o_gpio_we !== o_gpio_stb || (o_gpio_stb === 1'b1 && o_gpio_cyc !== 1'b1) || o_wb_stall !== 1'b0) viol++;
    end

    // GPIO slave: stalls rs_stall cycles per strobe, acks rs_lat cycles after acceptance
    initial begin
        forever begin
            i_gpio_ack = 1'b0;
            i_gpio_stall = 1'b0;
            if (o_gpio_stb !== 1'b1) @(negedge clk);
            else begin
                for (int k = 0; k < rs_stall && o_gpio_stb === 1'b1; k++) begin
                    i_gpio_stall = 1'b1;
                    @(negedge clk);
                end
                if (o_gpio_stb === 1'b1) begin
                    i_gpio_stall = 1'b0;
                    i_gpio_ack = (rs_lat == 0) && !rs_noack;
                    rs_cap = o_gpio_data;
                    @(negedge clk);
                    acc_edge.push_back(cyc_n);
                    acc_data.push_back(rs_cap);
                    if (rs_lat > 0 && !rs_noack) begin
                        i_gpio_ack = 1'b0;
                        for (int k = 1; k < rs_lat; k++) @(negedge clk);
                        if (o_gpio_cyc === 1'b1) begin
                            i_gpio_ack = 1'b1;
                            @(negedge clk);
                        end
                    end
                end
            end
        end
    end

    // Expected accept edges: strobe rises after edge t, accepted S edges later; next t = ack + delay
    function automatic void model_run(input int start_edge, input int last, input bit loop,
                                      input int nwr, input int s, input int l);
        int t, st, acc, fin;
        t = start_edge;
        st = 0;
        exp_edge.delete();
        exp_data.delete();
        exp_done = -1;
        for (int k = 0; k < nwr; k++) begin
            acc = t + 1 + s;
            exp_edge.push_back(acc);
            exp_data.push_back(tab_w[st]);
            fin = acc + l + tab_d[st];
            if (st == last) begin
                if (!loop) begin
                    exp_done = fin;
                    return;
                end
                st = 0;
            end else begin
                st++;
            end
            t = fin;
        end
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
        @(negedge clk);
        wr_edge = cyc_n;
        wr_ack = o_wb_ack;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d, output logic ack);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
        @(negedge clk);
        d = o_wb_data;
        ack = o_wb_ack;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    endtask

    task automatic load_step(input int st, input logic [31:0] w, input int d);
        tab_w[st] = w;
        tab_d[st] = d;
        wb_write(5'(16 + 2 * st), w);
        wb_write(5'(17 + 2 * st), 32'(d));
    endtask

    task automatic wait_acc(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (acc_edge.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_int(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (int_edge.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic clear_logs();
        acc_edge.delete(); acc_data.delete(); int_edge.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic ack;
        repeat (3) @(negedge clk);
        n_cmp++; if ({o_wb_ack, o_gpio_cyc, o_gpio_stb, o_gpio_we, o_int} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 00000", {o_wb_ack, o_gpio_cyc, o_gpio_stb, o_gpio_we, o_int}); end
        n_cmp++; if ({o_gpio_data, o_wb_data} !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h exp 0/0", o_gpio_data, o_wb_data); end
        rst = 1'b0;
        @(negedge clk);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (ack !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got ack=%b %h exp ack=1 00000000", ack, rd); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic ack;
        bit ok;
        rs_stall = 0; rs_lat = 1; rs_noack = 0;
        load_step(0, 32'h0001_0001, 3);
        load_step(1, 32'h0001_0000, 0);
        n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL write_ack: got %b exp 1", wr_ack); end
        wb_read(5'd16, rd, ack);
        n_cmp++; if (rd !== 32'h0001_0001) begin n_fail++; $display("FAIL tab_word_rd: got %h exp 00010001", rd); end
        wb_read(5'd17, rd, ack);
        n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL tab_dly_rd: got %h exp 00000003", rd); end
        wb_read(5'd3, rd, ack);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h exp 00000000", rd); end
        clear_logs();
        wb_write(5'd0, 32'h0101);
        model_run(wr_edge, 1, 1'b0, 8, 0, 1);
        wait_int(1, 100, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL oneshot_wait: got %0d int pulses exp 1", int_edge.size()); end
        repeat (4) @(negedge clk);
        n_cmp++; if (acc_edge.size() !== 2) begin n_fail++; $display("FAIL oneshot_nwr: got %0d exp 2", acc_edge.size()); end
        for (int k = 0; k < 2 && k < acc_edge.size(); k++) begin
            n_cmp++; if (acc_data[k] !== exp_data[k] || acc_edge[k] !== exp_edge[k]) begin n_fail++; $display("FAIL oneshot_wr%0d: got %h@%0d exp %h@%0d", k, acc_data[k], acc_edge[k], exp_data[k], exp_edge[k]); end
        end
        n_cmp++; if (int_edge.size() !== 1 || int_edge[0] !== exp_done) begin n_fail++; $display("FAIL oneshot_int: got %0d pulses first@%0d exp 1@%0d", int_edge.size(), int_edge.size() > 0 ? int_edge[0] : -1, exp_done); end
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h0110) begin n_fail++; $display("FAIL oneshot_ctrl: got %h exp 00000110", rd); end
    endtask

    task automatic test_random_seq();
        logic [31:0] rd;
        logic ack;
        bit ok;
        int last;
        for (int it = 0; it < 4; it++) begin
            for (int st = 0; st < 8; st++) load_step(st, $urandom, int'($urandom_range(0, 4)));
            last = int'($urandom_range(0, 7));
            rs_stall = int'($urandom_range(0, 2));
            rs_lat = int'($urandom_range(0, 3));
            clear_logs();
            wb_write(5'd0, 32'(1 | (last << 8)));
            model_run(wr_edge, last, 1'b0, 16, rs_stall, rs_lat);
            wait_int(1, 400, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand%0d_wait: got %0d int pulses exp 1", it, int_edge.size()); end
            repeat (3) @(negedge clk);
            n_cmp++; if (acc_edge.size() !== exp_edge.size()) begin n_fail++; $display("FAIL rand%0d_nwr: got %0d exp %0d", it, acc_edge.size(), exp_edge.size()); end
            for (int k = 0; k < acc_edge.size() && k < exp_edge.size(); k++) begin
                n_cmp++; if (acc_data[k] !== exp_data[k] || acc_edge[k] !== exp_edge[k]) begin n_fail++; $display("FAIL rand%0d_wr%0d: got %h@%0d exp %h@%0d", it, k, acc_data[k], acc_edge[k], exp_data[k], exp_edge[k]); end
            end
            n_cmp++; if (int_edge.size() !== 1 || int_edge[0] !== exp_done) begin n_fail++; $display("FAIL rand%0d_int: got %0d pulses first@%0d exp 1@%0d", it, int_edge.size(), int_edge.size() > 0 ? int_edge[0] : -1, exp_done); end
            wb_read(5'd0, rd, ack);
            n_cmp++; if (rd !== 32'(32'h10 | (last << 8))) begin n_fail++; $display("FAIL rand%0d_ctrl: got %h exp %h", it, rd, 32'(32'h10 | (last << 8))); end
        end
    endtask

    task automatic test_loop_abort();
        logic [31:0] rd;
        logic ack;
        bit ok;
        int hi0;
        rs_stall = 0; rs_lat = 1; rs_noack = 0;
        load_step(0, 32'h0001_0001, 3);
        load_step(1, 32'h0001_0000, 0);
        clear_logs();
        wb_write(5'd0, 32'h0103);
        model_run(wr_edge, 1, 1'b1, 6, 0, 1);
        wait_acc(6, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL loop_wait: got %0d writes exp 6", acc_edge.size()); end
        for (int k = 0; k < 6 && k < acc_edge.size(); k++) begin
            n_cmp++; if (acc_data[k] !== exp_data[k] || acc_edge[k] !== exp_edge[k]) begin n_fail++; $display("FAIL loop_wr%0d: got %h@%0d exp %h@%0d", k, acc_data[k], acc_edge[k], exp_data[k], exp_edge[k]); end
        end
        wb_write(5'd0, 32'h4);
        n_cmp++; if (o_gpio_cyc !== 1'b0 || o_gpio_stb !== 1'b0) begin n_fail++; $display("FAIL abort_cyc: got cyc=%b stb=%b exp 0 0", o_gpio_cyc, o_gpio_stb); end
        hi0 = cyc_hi;
        repeat (8) @(negedge clk);
        n_cmp++; if (cyc_hi !== hi0) begin n_fail++; $display("FAIL abort_quiet: got %0d cyc cycles exp 0", cyc_hi - hi0); end
        wb_read(5'd0, rd, ack);
        n_cmp++; if ((rd & 32'h1f) !== 32'h0) begin n_fail++; $display("FAIL abort_ctrl: got %h exp low bits 00", rd); end
        n_cmp++; if (int_edge.size() !== 0) begin n_fail++; $display("FAIL abort_int: got %0d pulses exp 0", int_edge.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        int hi, bad;
        logic [31:0] w;
        w = $urandom;
        rs_stall = 5; rs_lat = 0; rs_noack = 0;
        load_step(0, w, 0);
        clear_logs();
        wb_write(5'd0, 32'h0001);
        model_run(wr_edge, 0, 1'b0, 4, 5, 0);
        hi = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_gpio_stb === 1'b1) begin
                hi++;
                if (o_gpio_data !== w) bad++;
            end
            @(negedge clk);
        end
        n_cmp++; if (hi !== 6) begin n_fail++; $display("FAIL stall_stb_len: got %0d exp 6", hi); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL stall_data: got %0d unstable cycles exp 0", bad); end
        n_cmp++; if (acc_edge.size() !== 1 || acc_edge[0] !== exp_edge[0] || acc_data[0] !== w) begin n_fail++; $display("FAIL stall_wr: got %0d writes first@%0d exp 1@%0d", acc_edge.size(), acc_edge.size() > 0 ? acc_edge[0] : -1, exp_edge[0]); end
        n_cmp++; if (int_edge.size() !== 1 || int_edge[0] !== exp_done) begin n_fail++; $display("FAIL stall_int: got %0d pulses exp 1@%0d", int_edge.size(), exp_done); end
        wait_int(1, 1, ok);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        logic ack;
        bit ok;
        int a;
        rs_stall = 0; rs_lat = 1; rs_noack = 1;
        load_step(0, 32'h00ff_00aa, 2);
        clear_logs();
        wb_write(5'd0, 32'h0001);
        wait_acc(1, 50, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL tmo_acc_wait: got %0d writes exp 1", acc_edge.size()); end
        a = ok ? acc_edge[0] : cyc_n;
        while (cyc_n < a + TMO - 1) @(negedge clk);
        n_cmp++; if (o_gpio_cyc !== 1'b1) begin n_fail++; $display("FAIL tmo_cyc_hold: got %b exp 1", o_gpio_cyc); end
        @(negedge clk);
        n_cmp++; if (o_gpio_cyc !== 1'b0 || o_int !== 1'b1) begin n_fail++; $display("FAIL tmo_drop: got cyc=%b int=%b exp 0 1", o_gpio_cyc, o_int); end
        @(negedge clk);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h08) begin n_fail++; $display("FAIL tmo_ctrl: got %h exp 00000008", rd); end
        rs_noack = 0;
        clear_logs();
        wb_write(5'd0, 32'h0001);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h01) begin n_fail++; $display("FAIL tmo_restart_ctrl: got %h exp 00000001", rd); end
        wait_int(1, 50, ok);
        repeat (2) @(negedge clk);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (!ok || rd !== 32'h10) begin n_fail++; $display("FAIL tmo_rerun: got ok=%b ctrl=%h exp 1 00000010", ok, rd); end
    endtask

    task automatic test_busy_start();
        logic [31:0] rd;
        logic ack;
        bit ok;
        rs_stall = 0; rs_lat = 1; rs_noack = 0;
        load_step(0, 32'h0003_0002, 6);
        load_step(1, 32'h0003_0001, 4);
        clear_logs();
        wb_write(5'd0, 32'h0101);
        model_run(wr_edge, 1, 1'b0, 8, 0, 1);
        wait_acc(1, 50, ok);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h0101) begin n_fail++; $display("FAIL busy_step0: got %h exp 00000101", rd); end
        wb_write(5'd0, 32'h0101);
        wait_acc(2, 50, ok);
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h0001_0101) begin n_fail++; $display("FAIL busy_step1: got %h exp 00010101", rd); end
        wait_int(1, 100, ok);
        repeat (15) @(negedge clk);
        n_cmp++; if (acc_edge.size() !== 2) begin n_fail++; $display("FAIL busy_nwr: got %0d exp 2", acc_edge.size()); end
        for (int k = 0; k < 2 && k < acc_edge.size(); k++) begin
            n_cmp++; if (acc_data[k] !== exp_data[k] || acc_edge[k] !== exp_edge[k]) begin n_fail++; $display("FAIL busy_wr%0d: got %h@%0d exp %h@%0d", k, acc_data[k], acc_edge[k], exp_data[k], exp_edge[k]); end
        end
        n_cmp++; if (int_edge.size() !== 1 || int_edge[0] !== exp_done) begin n_fail++; $display("FAIL busy_int: got %0d pulses exp 1@%0d", int_edge.size(), exp_done); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic ack;
        bit ok;
        int hi0;
        rs_stall = 0; rs_lat = 1; rs_noack = 1;
        load_step(0, 32'h0010_0010, 1);
        clear_logs();
        wb_write(5'd0, 32'h0001);
        wait_acc(1, 50, ok);
        n_cmp++; if (o_gpio_cyc !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got cyc=%b exp 1", o_gpio_cyc); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_gpio_cyc !== 1'b0 || o_int !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got cyc=%b int=%b exp 0 0", o_gpio_cyc, o_int); end
        @(negedge clk);
        rst = 1'b0;
        rs_noack = 0;
        hi0 = cyc_hi;
        repeat (10) @(negedge clk);
        n_cmp++; if (cyc_hi !== hi0 || acc_edge.size() !== 1) begin n_fail++; $display("FAIL rstmid_quiet: got %0d cyc cycles %0d writes exp 0 1", cyc_hi - hi0, acc_edge.size()); end
        wb_read(5'd0, rd, ack);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h exp 00000000", rd); end
    endtask

    task automatic test_protocol();
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL protocol: got %0d bad cycles exp 0", viol); end
    endtask

    initial begin
        rst = 1'b1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        test_reset();
        test_oneshot();
        test_random_seq();
        test_loop_abort();
        test_stall();
        test_timeout();
        test_busy_start();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
